// File: rtl/video_mode_pkg.sv
// Video timing records shared by the raster generator and anything that needs
// the mode geometry (totals, sync windows, coordinate width).
package video_mode_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    // Polarity bits: 1 = sync pulse is driven high while active.
    typedef struct packed {
        coord_t h_active;
        coord_t h_front;
        coord_t h_sync;
        coord_t h_back;
        coord_t v_active;
        coord_t v_front;
        coord_t v_sync;
        coord_t v_back;
        logic   h_pol;
        logic   v_pol;
    } video_mode_t;

    // Bundle carried through the sync delay line, MSB first.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bus_t;

    localparam video_mode_t VMODE_640x480p60 = '{
        h_active: 11'd640,
        h_front:  11'd16,
        h_sync:   11'd96,
        h_back:   11'd48,
        v_active: 11'd480,
        v_front:  11'd10,
        v_sync:   11'd2,
        v_back:   11'd33,
        h_pol:    1'b0,
        v_pol:    1'b0
    };

    function automatic coord_t h_total(input video_mode_t m);
        return m.h_active + m.h_front + m.h_sync + m.h_back;
    endfunction

    function automatic coord_t v_total(input video_mode_t m);
        return m.v_active + m.v_front + m.v_sync + m.v_back;
    endfunction

    function automatic coord_t h_sync_start(input video_mode_t m);
        return m.h_active + m.h_front;
    endfunction

    function automatic coord_t v_sync_start(input video_mode_t m);
        return m.v_active + m.v_front;
    endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Enable-gated shift register used to align sync/DE with a pixel pipeline.
// DEPTH = 0 degenerates to a wire so callers need no special casing.
module pix_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, en, rst_val};
            assign dout      = din;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] stage_q;
            logic [DEPTH-1:0][WIDTH-1:0] stage_d;

            always_comb begin
                stage_d = stage_q;
                if (en) begin
                    stage_d[0] = din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_q <= {DEPTH{rst_val}};
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, counters, registered sync/DE decode,
// line/frame strobes and a pixel-aligned delayed copy of sync/DE.
module vga_timing_gen
    import video_mode_pkg::*;
#(
    parameter video_mode_t VIDEO_MODE = VMODE_640x480p60,
    parameter int          CLK_DIV    = 4,
    parameter int          SYNC_DELAY = 0
) (
    input  logic               clk_100m,
    input  logic               reset,
    output logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic               hsync_d,
    output logic               vsync_d,
    output logic               de_d
);

    localparam int DIV_W = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam coord_t H_LAST   = h_total(VIDEO_MODE) - 11'd1;
    localparam coord_t V_LAST   = v_total(VIDEO_MODE) - 11'd1;
    localparam coord_t H_ACT    = VIDEO_MODE.h_active;
    localparam coord_t V_ACT    = VIDEO_MODE.v_active;
    localparam coord_t HS_START = h_sync_start(VIDEO_MODE);
    localparam coord_t HS_END   = h_sync_start(VIDEO_MODE) + VIDEO_MODE.h_sync;
    localparam coord_t VS_START = v_sync_start(VIDEO_MODE);
    localparam coord_t VS_END   = v_sync_start(VIDEO_MODE) + VIDEO_MODE.v_sync;
    localparam logic   H_IDLE   = ~VIDEO_MODE.h_pol;
    localparam logic   V_IDLE   = ~VIDEO_MODE.v_pol;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    coord_t           h_cnt_q, h_cnt_d;
    coord_t           v_cnt_q, v_cnt_d;
    logic             pix_en_q, pix_en_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             act_q, act_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic             tick;
    sync_bus_t        dly_in, dly_out, dly_rst;

    // The edge that raises pix_en is also the edge that moves the raster, so
    // pix_en marks the first clock of each new pixel.
    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Decode from the next counter values so the registered outputs line up
    // with x/y on the same clock.
    always_comb begin
        pix_en_d = tick;
        line_d   = tick && (h_cnt_d == '0);
        frame_d  = line_d && (v_cnt_d == '0);
        hs_d     = ((h_cnt_d >= HS_START) && (h_cnt_d < HS_END)) ? ~H_IDLE : H_IDLE;
        vs_d     = ((v_cnt_d >= VS_START) && (v_cnt_d < VS_END)) ? ~V_IDLE : V_IDLE;
        act_d    = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    end

    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            h_cnt_q   <= H_LAST;
            v_cnt_q   <= V_LAST;
            pix_en_q  <= 1'b0;
            hs_q      <= H_IDLE;
            vs_q      <= V_IDLE;
            act_q     <= 1'b0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            pix_en_q  <= pix_en_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            act_q     <= act_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
        end
    end

    // Shifting the currently displayed values on each pixel edge gives a lag
    // of exactly SYNC_DELAY pixel periods.
    assign dly_in  = '{hs: hs_q, vs: vs_q, de: act_q};
    assign dly_rst = '{hs: H_IDLE, vs: V_IDLE, de: 1'b0};

    pix_delay_line #(
        .DEPTH (SYNC_DELAY),
        .WIDTH (3)
    ) u_sync_dly (
        .clk     (clk_100m),
        .rst     (reset),
        .en      (tick),
        .rst_val (dly_rst),
        .din     (dly_in),
        .dout    (dly_out)
    );

    assign pix_en      = pix_en_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign de          = act_q;
    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;
    assign hsync_d     = dly_out.hs;
    assign vsync_d     = dly_out.vs;
    assign de_d        = dly_out.de;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates VGA raster timing for the Display stage from the 100 MHz fabric clock. It produces a pixel-rate clock enable, hsync/vsync, data-enable, pixel coordinates and line/frame strobes. Pixel sources upstream of the VGA pins use these to produce RGB for the current coordinate. Delayed sync/DE copies let the RGB pipeline latency be absorbed without extra logic in Display.

Parameters:
VIDEO_MODE, VMODE_640x480p60, video_mode_t timing record from video_mode_pkg: active, front, sync and back counts per axis, plus sync polarities.
CLK_DIV, 4, clk_100m cycles per pixel; 100 MHz / 4 = 25 MHz pixel rate; legal values 1..16.
SYNC_DELAY, 0, pixel periods of delay applied to hsync_d/vsync_d/de_d; legal values 0..8.

Ports:
clk_100m  in  1  fabric clock, 100 MHz
reset  in  1  asynchronous, active-high reset
pix_en  out  1  one-clk_100m-cycle pulse per pixel period
hsync  out  1  horizontal sync, polarity per VIDEO_MODE
vsync  out  1  vertical sync, polarity per VIDEO_MODE
de  out  1  high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
x  out  11  current horizontal count h_cnt, 0..H_TOTAL-1
y  out  11  current vertical count v_cnt, 0..V_TOTAL-1
line_start  out  1  one-cycle pulse when h_cnt becomes 0
frame_start  out  1  one-cycle pulse when h_cnt and v_cnt both become 0
hsync_d  out  1  hsync delayed by SYNC_DELAY pixel periods
vsync_d  out  1  vsync delayed by SYNC_DELAY pixel periods
de_d  out  1  de delayed by SYNC_DELAY pixel periods

Behaviour:
- Totals: H_TOTAL = active + front + sync + back on the horizontal axis; V_TOTAL is the same on the vertical axis. For 640x480p60: 800 and 525.
- Reset, asynchronous, all registers:
  - div_cnt = 0.
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so x = 799 and y = 524.
  - hsync, vsync, hsync_d and vsync_d at their inactive level.
  - de = de_d = 0; pix_en, line_start and frame_start = 0.
  - Outputs take these values immediately on reset assertion, with no clock required.
- Clock divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and is high on the cycle after div_cnt == CLK_DIV-1.
  - First pix_en is high exactly CLK_DIV cycles after the first rising edge with reset low.
  - CLK_DIV = 1: pix_en is high every cycle after reset release.
- Counters advance only in cycles where pix_en is high:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - On the h_cnt wrap, v_cnt increments; at V_TOTAL-1 it wraps to 0.
  - No other state changes when pix_en is low.
- Decode is registered on the same edge as the counter update, computed from the next counter values. This makes hsync, vsync, de, x and y mutually consistent in every cycle (zero skew).
  - hsync is active for h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). For 640x480: 656..751, active low.
  - vsync is active for v_cnt in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC). For 640x480: 490..491, active low.
- Strobes:
  - line_start and frame_start are high for exactly one clk_100m cycle, coincident with the pix_en edge that loads h_cnt = 0.
  - frame_start additionally requires v_cnt = 0.
  - The first pix_en after reset loads (0,0), so the first frame_start fires then.
- Delay line:
  - SYNC_DELAY-stage shift register on {hsync, vsync, de}, shifting only on pix_en.
  - Stages reset to inactive levels.
  - SYNC_DELAY = 0: the _d outputs are wired to the undelayed outputs.
- Mid-operation reset: the whole raster restarts from the reset state; no partial line is completed.
- Arithmetic: counters are 11-bit unsigned, with wrap by compare (not overflow). Compares use the constants from the package.

Decomposition:
- video_mode_pkg:
  - video_mode_t record with h_active, h_front, h_sync, h_back, v_active, v_front, v_sync, v_back, h_pol, v_pol.
  - VMODE_640x480p60 constant.
  - Helper functions h_total() and v_total().
  - COORD_W = 11 localparam.
- Sub-module pix_delay_line (parameter DEPTH, WIDTH = 3): enable-gated shift register with async reset value input; covers DEPTH = 0 as pass-through.

Test Plan:
1. Reset held 10 cycles, then released → outputs at reset values while held; first pix_en and frame_start both high 4 cycles after release, with x = 0, y = 0, de = 1.
2. Free run one line → pix_en period 4 clk; line_start period 3200 clk; hsync low for 384 clk starting at x = 656; de high for 2560 clk per active line.
3. Free run two frames → frame_start spacing 1,680,000 clk; vsync low during y = 490..491 only; de-high pixel periods per frame = 307,200.
4. Reset asserted asynchronously mid-line at x = 300, y = 100, between clock edges → all outputs reach reset values with no clock edge; after release, the sequence matches scenario 1.
5. SYNC_DELAY = 2 → hsync_d falls 8 clk after hsync; de_d rises 8 clk after de; _d outputs otherwise identical to the undelayed outputs.
6. CLK_DIV = 1, small custom mode (4/1/1/1 horizontal, 2/1/1/1 vertical) → pix_en constant high; x cycles 0..6; y cycles 0..4; hsync active only at x = 5.
